// File: rtl/bp_fe_ras_ctrl.sv
// bp_fe_ras_ctrl: return-address stack with checkpoint/restore of {count, top pointer}
module bp_fe_ras_ctrl #(
    parameter int vaddr_width_p = 39,
    parameter int ras_els_p = 8,
    localparam int ptr_width_lp = $clog2(ras_els_p),
    localparam int cnt_width_lp = $clog2(ras_els_p + 1)
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic                                 scan_v_i,
    input  logic                                 call_i,
    input  logic                                 ret_i,
    input  logic                                 compressed_i,
    input  logic [vaddr_width_p-1:0]             pc_i,
    output logic                                 tgt_v_o,
    output logic [vaddr_width_p-1:0]             tgt_o,
    output logic [ptr_width_lp+cnt_width_lp-1:0] ckpt_o,
    input  logic                                 restore_v_i,
    input  logic [ptr_width_lp+cnt_width_lp-1:0] restore_ckpt_i,
    input  logic                                 flush_i
);

    typedef enum logic [1:0] {IDLE, PUSH, POP, SWAP} op_e;

    logic [vaddr_width_p-1:0] mem [ras_els_p];
    logic [ptr_width_lp-1:0]  ptr, ptr_n, waddr;
    logic [cnt_width_lp-1:0]  cnt, cnt_n;
    logic [vaddr_width_p-1:0] ra;
    logic                     empty, full, we;
    op_e                      op;

    assign ra    = pc_i + (compressed_i ? vaddr_width_p'(2) : vaddr_width_p'(4));
    assign empty = cnt == '0;
    assign full  = cnt == cnt_width_lp'(ras_els_p);

    assign tgt_o   = mem[ptr];
    assign tgt_v_o = !empty;
    assign ckpt_o  = {cnt, ptr};

    // Decode the scan event; flush and restore suppress it, and a swap on an empty stack is a push
    always_comb begin
        op = IDLE;
        if (scan_v_i && !flush_i && !restore_v_i)
            op = call_i ? ((ret_i && !empty) ? SWAP : PUSH) : (ret_i ? POP : IDLE);
    end

    // Next pointer/count and the single write port, prioritised flush > restore > scan
    always_comb begin
        ptr_n = ptr;
        cnt_n = cnt;
        we    = 1'b0;
        waddr = ptr;
        if (flush_i) begin
            cnt_n = '0;
        end else if (restore_v_i) begin
            {cnt_n, ptr_n} = restore_ckpt_i;
        end else if (op == PUSH) begin
            ptr_n = ptr + ptr_width_lp'(1);
            cnt_n = full ? cnt : cnt + cnt_width_lp'(1);
            we    = 1'b1;
            waddr = ptr + ptr_width_lp'(1);
        end else if (op == POP && !empty) begin
            ptr_n = ptr - ptr_width_lp'(1);
            cnt_n = cnt - cnt_width_lp'(1);
        end else if (op == SWAP) begin
            we    = 1'b1;
        end
    end

    // Pointer and occupancy registers, cleared asynchronously
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ptr <= '0;
            cnt <= '0;
        end else begin
            ptr <= ptr_n;
            cnt <= cnt_n;
        end
    end

    // Entry storage is never cleared; stale entries are hidden by the count
    always_ff @(posedge clk_i) begin
        if (we) mem[waddr] <= ra;
    end

endmodule

// File: tb/tb_bp_fe_ras_ctrl.sv
// tb_bp_fe_ras_ctrl: directed and randomized checks of the RAS controller against a stack model
module tb_bp_fe_ras_ctrl;

    localparam int VW = 39;
    localparam int N  = 8;

    logic          clk = 1'b0;
    logic          reset_i, scan_v_i, call_i, ret_i, compressed_i, restore_v_i, flush_i;
    logic [VW-1:0] pc_i, tgt_o;
    logic          tgt_v_o;
    logic [6:0]    ckpt_o, restore_ckpt_i;

    int total = 0;
    int bad = 0;

    logic [VW-1:0] m_mem [N];
    int            m_ptr, m_cnt;
    logic [6:0]    hist [$];
    logic [6:0]    ck;

    always #5 clk = ~clk;

    bp_fe_ras_ctrl dut (
        .clk_i(clk), .reset_i(reset_i), .scan_v_i(scan_v_i), .call_i(call_i), .ret_i(ret_i),
        .compressed_i(compressed_i), .pc_i(pc_i), .tgt_v_o(tgt_v_o), .tgt_o(tgt_o),
        .ckpt_o(ckpt_o), .restore_v_i(restore_v_i), .restore_ckpt_i(restore_ckpt_i),
        .flush_i(flush_i)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] m_ckpt();
        return {4'(m_cnt), 3'(m_ptr)};
    endfunction

    // Stack semantics: push grows a circular stack, pop shrinks it, swap replaces the top
    task automatic model_step();
        logic [VW-1:0] ra;
        ra = pc_i + (compressed_i ? VW'(2) : VW'(4));
        if (reset_i) begin
            m_ptr = 0;
            m_cnt = 0;
        end else if (flush_i) m_cnt = 0;
        else if (restore_v_i) begin
            m_cnt = int'(restore_ckpt_i[6:3]);
            m_ptr = int'(restore_ckpt_i[2:0]);
        end else if (scan_v_i) begin
            if (call_i && ret_i && m_cnt > 0) m_mem[m_ptr] = ra;
            else if (call_i) begin
                m_ptr = (m_ptr + 1) % N;
                m_mem[m_ptr] = ra;
                if (m_cnt < N) m_cnt++;
            end else if (ret_i && m_cnt > 0) begin
                m_ptr = (m_ptr + N - 1) % N;
                m_cnt--;
            end
        end
    endtask

    task automatic check_model();
        chk("tgt_v", 64'(tgt_v_o), 64'(m_cnt != 0));
        chk("ckpt", 64'(ckpt_o), 64'(m_ckpt()));
        if (m_cnt != 0) chk("tgt", 64'(tgt_o), 64'(m_mem[m_ptr]));
    endtask

    task automatic idle();
        scan_v_i = 0; call_i = 0; ret_i = 0; compressed_i = 0;
        restore_v_i = 0; flush_i = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_model();
        idle();
    endtask

    task automatic scan(input logic c, input logic r, input logic cmp, input logic [VW-1:0] pc);
        scan_v_i = 1; call_i = c; ret_i = r; compressed_i = cmp; pc_i = pc;
        cyc();
    endtask

    initial begin
        reset_i = 1; pc_i = '0; restore_ckpt_i = '0;
        idle();
        m_ptr = 0; m_cnt = 0;
        for (int i = 0; i < N; i++) m_mem[i] = '0;
        #1;
        chk("reset_tgt_v", 64'(tgt_v_o), 64'(0));
        chk("reset_ckpt", 64'(ckpt_o), 64'(0));
        @(posedge clk); #1;
        reset_i = 0;

        scan(1, 0, 0, 39'h80000000);
        chk("push_tgt", 64'(tgt_o), 64'h80000004);
        chk("push_ckpt", 64'(ckpt_o), 64'h09);
        scan(0, 1, 0, '0);
        chk("pop_empty", 64'(tgt_v_o), 64'(0));
        chk("pop_cnt", 64'(ckpt_o[6:3]), 64'(0));

        scan(1, 0, 1, 39'h7F_FFFF_FFFE);
        chk("wrap_tgt", 64'(tgt_o), 64'h0);
        scan(1, 0, 1, 39'h100);
        chk("cpush_tgt", 64'(tgt_o), 64'h102);

        flush_i = 1; cyc();
        chk("flush_cnt", 64'(ckpt_o[6:3]), 64'(0));
        for (int k = 1; k <= 10; k++) scan(1, 0, 0, VW'(16 * k));
        chk("ovf_cnt", 64'(ckpt_o[6:3]), 64'(8));
        for (int i = 1; i <= 8; i++) begin
            chk("ovf_pop", 64'(tgt_o), 64'(16 * (11 - i) + 4));
            scan(0, 1, 0, '0);
        end
        chk("udf_v", 64'(tgt_v_o), 64'(0));
        scan(0, 1, 0, '0);
        chk("udf_cnt", 64'(ckpt_o[6:3]), 64'(0));

        scan(1, 0, 0, 39'h200);
        scan(1, 1, 0, 39'h300);
        chk("swap_tgt", 64'(tgt_o), 64'h304);
        chk("swap_cnt", 64'(ckpt_o[6:3]), 64'(1));
        flush_i = 1; cyc();
        scan(1, 1, 0, 39'h400);
        chk("swap_empty_cnt", 64'(ckpt_o[6:3]), 64'(1));
        chk("swap_empty_tgt", 64'(tgt_o), 64'h404);

        flush_i = 1; cyc();
        scan(1, 0, 0, 39'hA00);
        scan(1, 0, 0, 39'hB00);
        ck = m_ckpt();
        scan(1, 0, 0, 39'hC00);
        scan(0, 1, 0, '0);
        scan(0, 1, 0, '0);
        restore_v_i = 1; restore_ckpt_i = ck;
        scan(1, 0, 0, 39'hD00);
        chk("restore_cnt", 64'(ckpt_o[6:3]), 64'(2));
        chk("restore_tgt", 64'(tgt_o), 64'hB04);
        flush_i = 1; restore_v_i = 1; restore_ckpt_i = ck; cyc();
        chk("flush_over_restore", 64'(ckpt_o[6:3]), 64'(0));

        for (int k = 0; k < 3; k++) scan(1, 0, 0, VW'(32'h1000 * (k + 1)));
        chk("pre_reset_cnt", 64'(ckpt_o[6:3]), 64'(3));
        #2 reset_i = 1;
        #1;
        chk("async_tgt_v", 64'(tgt_v_o), 64'(0));
        chk("async_ckpt", 64'(ckpt_o), 64'(0));
        cyc();
        #2 reset_i = 0;
        scan(1, 0, 0, 39'h5000);
        chk("post_reset_ckpt", 64'(ckpt_o), 64'h09);

        hist.delete();
        for (int t = 0; t < 3000; t++) begin
            int r;
            r = int'($urandom_range(0, 63));
            flush_i = (r == 0);
            restore_v_i = (r < 5) && (hist.size() > 0);
            if (hist.size() > 0) restore_ckpt_i = hist[$urandom_range(0, hist.size() - 1)];
            scan_v_i = ($urandom_range(0, 3) != 0);
            call_i = $urandom_range(0, 1) == 1;
            ret_i = $urandom_range(0, 1) == 1;
            compressed_i = $urandom_range(0, 1) == 1;
            pc_i = ($urandom_range(0, 7) == 0) ? ~VW'($urandom_range(0, 3)) : {$urandom, $urandom};
            cyc();
            hist.push_back(m_ckpt());
            if (hist.size() > 16) void'(hist.pop_front());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bp_fe_ras_ctrl.md
Name: bp_fe_ras_ctrl

Overview:
- Return-address-stack controller for the front end.
- Consumes per-fetch control-flow classification from the instruction scanner (call, ret, compressed) plus the fetch PC.
- Pushes predicted return addresses on calls and supplies a predicted target on returns.
- Checkpoints and restores its stack pointer across backend redirects so that mispredicted-path calls and returns are undone.

Parameters:
- vaddr_width_p, 39, virtual address width of PCs and targets.
- ras_els_p, 8, number of stack entries; power of two, ≥2.
- ptr_width_lp, $clog2(ras_els_p), derived local; width of the top-of-stack pointer.
- cnt_width_lp, $clog2(ras_els_p+1), derived local; width of the occupancy count.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- reset_i  input  1  reset, asynchronous, active-high.
- scan_v_i  input  1  scan result valid this cycle; call_i/ret_i are ignored when low.
- call_i  input  1  scanned instruction is a call.
- ret_i  input  1  scanned instruction is a return.
- compressed_i  input  1  scanned instruction is 16-bit.
- pc_i  input  vaddr_width_p  PC of the scanned instruction.
- tgt_v_o  output  1  stack non-empty; tgt_o is a valid prediction.
- tgt_o  output  vaddr_width_p  address at top of stack.
- ckpt_o  output  ptr_width_lp+cnt_width_lp  current {count, ptr}, sampled by the front end with each fetch.
- restore_v_i  input  1  backend redirect: restore from restore_ckpt_i.
- restore_ckpt_i  input  ptr_width_lp+cnt_width_lp  checkpoint to restore.
- flush_i  input  1  empty the stack (e.g. fence.i / satp change).

Behaviour:
- State:
  - entries mem[ras_els_p] of vaddr_width_p bits.
  - ptr: index of the current top.
  - cnt: number of valid entries, 0..ras_els_p.
- Reset (async, asserted at any time, including mid-operation):
  - ptr=0, cnt=0; tgt_v_o=0 immediately, ckpt_o=0.
  - mem contents are not cleared and are don't-care.
- Outputs (combinational from registered state):
  - tgt_o = mem[ptr].
  - tgt_v_o = (cnt != 0).
  - ckpt_o = {cnt, ptr}.
  - The ret that consumes the top sees it in the same cycle. A push becomes visible on the cycle after it is accepted.
- Return address: ra = pc_i + (compressed_i ? 2 : 4), modulo 2^vaddr_width_p (wrap at the top of the address space, carry discarded).
- Priority per cycle, highest first: flush_i > restore_v_i > scan event. Lower-priority inputs in the same cycle are dropped.
  - flush_i: cnt←0; ptr unchanged.
  - restore_v_i: {cnt, ptr}←restore_ckpt_i; mem unchanged.
- Scan event (scan_v_i=1), decoded as a four-state operation:
  - IDLE (neither call_i nor ret_i): no change.
  - PUSH (call_i only): ptr←ptr+1 mod ras_els_p; mem[ptr+1]←ra; cnt←min(cnt+1, ras_els_p).
    - Overflow: when cnt==ras_els_p, the oldest entry is overwritten (circular) and cnt stays saturated.
  - POP (ret_i only): if cnt>0, ptr←ptr−1 mod ras_els_p and cnt←cnt−1.
    - Underflow: when cnt==0, no change.
  - SWAP (call_i and ret_i, coroutine jalr): if cnt>0, mem[ptr]←ra with ptr and cnt unchanged. If cnt==0, behaves as PUSH.
- Pointer arithmetic is unsigned modulo ras_els_p.
- Only one mem write port is needed.
- Restored entries may hold wrong-path data. This is accepted as a prediction inaccuracy, not an error.
- Counts presented on restore_ckpt_i above ras_els_p are not produced by the front end and are out of scope.

Test Plan:
- Basic push/pop:
  - Reset, then call_i with pc_i=0x8000_0000, compressed_i=0 → next cycle tgt_v_o=1, tgt_o=0x8000_0004, ckpt_o cnt=1, ptr=1.
  - Then ret_i → following cycle tgt_v_o=0, cnt=0.
- Compressed call and address wrap:
  - call with pc_i=0x7F_FFFF_FFFE, compressed_i=1 → tgt_o=0x0.
  - Then call with pc_i=0x100, compressed_i=1 → tgt_o=0x102.
- Overflow and underflow (ras_els_p=8):
  - 10 calls with pc_i=0x10·k for k=1..10, compressed_i=0 → cnt=8; 8 pops return 0xA4, 0x94, … 0x34 in order.
  - A 9th pop → tgt_v_o=0 and cnt stays 0.
- SWAP:
  - Push 0x204 (call at pc_i=0x200), then call_i and ret_i together with pc_i=0x300 → tgt_o=0x304, cnt unchanged at 1.
  - SWAP on an empty stack → cnt=1.
- Checkpoint/restore:
  - Push A and B; capture ckpt_o; push C and pop twice.
  - Apply restore_v_i with the captured checkpoint together with call_i → cnt=2, tgt_o=B, call ignored.
  - flush_i together with restore_v_i → cnt=0.
- Async reset mid-operation:
  - With cnt=3, assert reset_i between clock edges → tgt_v_o and ckpt_o go to 0 before the next edge.
  - After deassertion, the first call → cnt=1, ptr=1.
